fpu_norm_arbiter: RTL and testbench

- Shares one combinational 25-bit leading-zero normaliser between two result producers, e.g. the add/sub path (requester 0) and the multiply path (requester 1).
- Arbitrates round-robin and applies the normaliser to the granted operand.
- Adjusts the biased exponent by the shift count and registers a single-precision-style {sign, exp, frac} result with a requester tag behind a valid/ready output handshake.

---
 rtl/fpu_norm_arbiter.sv | 93 +++++++++
 tb/tb_fpu_norm_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_arbiter.sv
// fpu_norm_arbiter: round-robin shared 25-bit leading-zero normaliser with registered output; FPU_NORM_SAT_EN enables ovf/unf saturation
module fpu_norm_arbiter #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_sign,
  input  logic [EXP_W-1:0]  req0_exp,
  input  logic [MANT_W-1:0] req0_mant,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_sign,
  input  logic [EXP_W-1:0]  req1_exp,
  input  logic [MANT_W-1:0] req1_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_tag,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-3:0] out_frac,
  output logic              out_ovf,
  output logic              out_unf
);
  logic ptr, gnt, any_v, can_load, xfer, zero, n_ovf, n_unf;
  logic [4:0] sh;
  logic [MANT_W-1:0] m, norm;
  logic [EXP_W-1:0] g_exp, n_exp;
  logic [MANT_W-3:0] n_frac;
  always_comb begin
    any_v = req0_valid | req1_valid;
    gnt = (req0_valid & req1_valid) ? ptr : req1_valid;
    can_load = !out_valid | out_ready;
    xfer = any_v & can_load;
    req0_ready = can_load & req0_valid & !gnt;
    req1_ready = can_load & req1_valid & gnt;
    m = gnt ? req1_mant : req0_mant;
    g_exp = gnt ? req1_exp : req0_exp;
  end
  // highest set bit wins because it is visited last; 31 marks an all-zero mantissa
  always_comb begin
    sh = 5'd31;
    for (int i = 0; i < MANT_W; i++) if (m[i]) sh = 5'(MANT_W - 1 - i);
  end
  assign norm = m << sh;
  assign zero = m == '0;
`ifdef FPU_NORM_SAT_EN
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
  logic signed [EXP_W+1:0] e;
  logic ovf, unf;
  always_comb begin
    e = $signed({2'b00, g_exp} + (EXP_W+2)'(1) - (EXP_W+2)'(sh));
    ovf = !zero && e >= E_MAX;
    unf = !zero && (e[EXP_W+1] || e == '0);
    n_exp = (zero || unf) ? '0 : ovf ? '1 : e[EXP_W-1:0];
    n_frac = (zero || ovf || unf) ? '0 : (MANT_W-2)'(norm >> 1);
    n_ovf = ovf;
    n_unf = unf;
  end
`else
  always_comb begin
    n_exp = zero ? '0 : g_exp + EXP_W'(1) - EXP_W'(sh);
    n_frac = (MANT_W-2)'(norm >> 1);
    n_ovf = 1'b0;
    n_unf = 1'b0;
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ptr <= 1'b0;
      out_tag <= 1'b0;
      out_sign <= 1'b0;
      out_exp <= '0;
      out_frac <= '0;
      out_ovf <= 1'b0;
      out_unf <= 1'b0;
    end else begin
      if (can_load) out_valid <= any_v;
      if (xfer) begin
        ptr <= !gnt;
        out_tag <= gnt;
        out_sign <= gnt ? req1_sign : req0_sign;
        out_exp <= n_exp;
        out_frac <= n_frac;
        out_ovf <= n_ovf;
        out_unf <= n_unf;
      end
    end
  end
endmodule

// File: tb/tb_fpu_norm_arbiter.sv
// tb_fpu_norm_arbiter: directed stimulus, per-cycle model compare plus literal spot checks
module tb_fpu_norm_arbiter;
  logic clk = 0, rst_n = 0, out_ready = 1;
  logic req0_valid = 0, req0_sign = 0, req1_valid = 0, req1_sign = 0;
  logic [7:0] req0_exp = 0, req1_exp = 0;
  logic [24:0] req0_mant = 0, req1_mant = 0;
  logic req0_ready, req1_ready, out_valid, out_tag, out_sign, out_ovf, out_unf;
  logic [7:0] out_exp;
  logic [22:0] out_frac;
  int checks = 0, errors = 0;

  fpu_norm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sign(req0_sign), .req0_exp(req0_exp), .req0_mant(req0_mant),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sign(req1_sign), .req1_exp(req1_exp), .req1_mant(req1_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_sign(out_sign),
    .out_exp(out_exp), .out_frac(out_frac), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // reference normaliser: locate leading one, align the bits below it, apply exponent rules
  task automatic model_norm(input logic [24:0] m, input logic [7:0] ex,
                            output logic [7:0] oe, output logic [22:0] of, output logic ov, output logic un);
    int p, e;
    longint f;
    p = -1;
    for (int i = 0; i < 25; i++) if (m[i]) p = i;
    ov = 0;
    un = 0;
    oe = 0;
    of = 0;
    if (p >= 0) begin
      e = int'(ex) + 1 - (24 - p);
      f = ((longint'(m) - (longint'(1) << p)) << 23) >> p;
      of = f[22:0];
      oe = e[7:0];
`ifdef FPU_NORM_SAT_EN
      if (e >= 255) begin oe = 8'hFF; of = 0; ov = 1; end
      else if (e <= 0) begin oe = 0; of = 0; un = 1; end
`endif
    end
  endtask

  logic m_valid = 0, m_ptr = 0, m_tag = 0, m_sign = 0, m_ovf = 0, m_unf = 0;
  logic [7:0] m_exp = 0;
  logic [22:0] m_frac = 0;

  always @(posedge clk) begin
    logic can, w, ov, un;
    logic [7:0] oe;
    logic [22:0] of;
    if (!rst_n) begin
      m_valid = 0; m_ptr = 0; m_tag = 0; m_sign = 0; m_exp = 0; m_frac = 0; m_ovf = 0; m_unf = 0;
    end else begin
      can = !m_valid || out_ready;
      w = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      if (can) begin
        m_valid = req0_valid || req1_valid;
        if (m_valid) begin
          model_norm(w ? req1_mant : req0_mant, w ? req1_exp : req0_exp, oe, of, ov, un);
          m_tag = w; m_sign = w ? req1_sign : req0_sign;
          m_exp = oe; m_frac = of; m_ovf = ov; m_unf = un;
          m_ptr = !w;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic can, w;
    can = !m_valid || out_ready;
    w = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    chk("req0_ready", req0_ready, rst_n && can && req0_valid && !w);
    chk("req1_ready", req1_ready, rst_n && can && req1_valid && w);
    chk("both_ready", req0_ready & req1_ready, 0);
    chk("out_valid", out_valid, m_valid);
    chk("out_tag", out_tag, m_tag);
    chk("out_sign", out_sign, m_sign);
    chk("out_exp", out_exp, m_exp);
    chk("out_frac", out_frac, m_frac);
    chk("out_ovf", out_ovf, m_ovf);
    chk("out_unf", out_unf, m_unf);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic s, input logic [7:0] e, input logic [24:0] m);
    req0_valid = v; req0_sign = s; req0_exp = e; req0_mant = m;
  endtask

  task automatic set1(input logic v, input logic s, input logic [7:0] e, input logic [24:0] m);
    req1_valid = v; req1_sign = s; req1_exp = e; req1_mant = m;
  endtask

  task automatic send0(input logic s, input logic [7:0] e, input logic [24:0] m);
    set0(1, s, e, m);
    step();
    req0_valid = 0;
  endtask

  initial begin
    logic [24:0] tbl [4] = '{25'h1FFFFFF, 25'h0400001, 25'h0000100, 25'h1234567};
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_exp", out_exp, 0);
    rst_n = 1;
    step();
    send0(0, 127, 25'h0800000);
    chk("single_valid", out_valid, 1);
    chk("single_tag", out_tag, 0);
    chk("single_exp", out_exp, 127);
    chk("single_frac", out_frac, 0);
    send0(0, 127, 25'h1000000);
    chk("carry_exp", out_exp, 128);
    chk("carry_frac", out_frac, 0);
    send0(1, 127, 25'h0000001);
    chk("deep_exp", out_exp, 104);
    chk("deep_sign", out_sign, 1);
    send0(0, 10, 25'h0C00000);
    chk("frac_exp", out_exp, 10);
    chk("frac_frac", out_frac, 23'h400000);
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    set0(1, 0, 100, 25'h0800000);
    set1(1, 1, 200, 25'h1000000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("contend_tag", out_tag, i % 2);
      chk("contend_exp", out_exp, (i % 2) ? 201 : 100);
    end
    set0(0, 0, 100, 25'h0800000);
    set1(0, 1, 200, 25'h1000000);
    step();
    chk("drain_valid", out_valid, 0);
    out_ready = 0;
    set0(1, 0, 100, 25'h0800000);
    set1(1, 1, 200, 25'h1000000);
    step();
    step();
    step();
    chk("stall_valid", out_valid, 1);
    chk("stall_tag", out_tag, 0);
    chk("stall_exp", out_exp, 100);
    out_ready = 1;
    step();
    chk("resume_tag1", out_tag, 1);
    chk("resume_exp1", out_exp, 201);
    step();
    chk("resume_tag0", out_tag, 0);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();
    send0(1, 50, 25'h0);
    chk("zero_exp", out_exp, 0);
    chk("zero_frac", out_frac, 0);
    chk("zero_flags", {out_ovf, out_unf}, 0);
    chk("zero_sign", out_sign, 1);
`ifdef FPU_NORM_SAT_EN
    send0(0, 20, 25'h0000001);
    chk("unf_exp", out_exp, 0);
    chk("unf_flag", out_unf, 1);
    send0(0, 20, 25'h0000003);
    chk("unf_frac", out_frac, 0);
    send0(0, 254, 25'h1000000);
    chk("ovf_exp", out_exp, 8'hFF);
    chk("ovf_flag", out_ovf, 1);
`else
    send0(0, 20, 25'h0000001);
    chk("unf_exp", out_exp, 8'hFD);
    chk("unf_flag", out_unf, 0);
    send0(0, 20, 25'h0000003);
    chk("unf_frac", out_frac, 23'h400000);
    send0(0, 254, 25'h1000000);
    chk("ovf_exp", out_exp, 8'hFF);
    chk("ovf_flag", out_ovf, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      set0(1, i[0], 8'(3 + 40 * i), tbl[i % 4]);
      set1(1, !i[0], 8'(250 - 30 * i), tbl[(i + 1) % 4]);
      out_ready = i[1] | i[0];
      step();
      if (req0_ready) req0_valid = 0;
      if (req1_ready) req1_valid = 0;
    end
    out_ready = 1;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();
    step();
    out_ready = 0;
    send0(0, 127, 25'h0800000);
    step();
    chk("prerst_valid", out_valid, 1);
    rst_n = 0;
    step();
    chk("midrst_valid", out_valid, 0);
    rst_n = 1;
    out_ready = 1;
    set0(1, 0, 100, 25'h0800000);
    set1(1, 1, 200, 25'h1000000);
    step();
    chk("postrst_tag", out_tag, 0);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
